qspi_mem_ctrl: RTL
==================

// Module: qspi_mem_ctrl
// PURPOSE
//  Quad-SPI master for the external storage SRAM; sits directly downstream of the MMU.
//  Accepts single-word read/write requests from the MMU and runs a full SQI transaction:
//  command, 24-bit address, optional dummy cycles, then data.
//  Returns read data or a write acknowledge.
// PARAMETERS
//  CLK_DIV     1     clk cycles per ck_o half-period (>=1); ck_o period = 2*CLK_DIV clk
//  DUMMY_CYC   2     ck_o periods of dummy between address and read data (0..15)
//  CS_HIGH_CYC 2     minimum clk cycles cs_o held high between transactions (>=1)
//  READ_CMD    8'h03 SQI read opcode
//  WRITE_CMD   8'h02 SQI write opcode
// PORTS
//  clk                 in     1   system clock
//  rst                 in     1   synchronous active-high reset
//  req_i               in     1   request valid from MMU
//  gnt_o               out    1   ready; request accepted on the cycle req_i && gnt_o
//  addr_i              in    32   byte address; bits [23:0] used, [1:0] must be 0
//  we_i                in     1   1 = write, 0 = read
//  be_i                in     4   write byte enables (ignored for reads)
//  wdata_i             in    32   write data (little-endian bytes)
//  rvalid_o            out    1   one-cycle response pulse (reads and writes)
//  err_o               out    1   valid with rvalid_o; request rejected
//  rdata_o             out   32   read data, valid with rvalid_o && !we of the request
//  busy_o              out    1   transaction in progress (~gnt_o)
//  external_qspi_pins  inout  4   SQI data IO[3:0]
//  external_qspi_ck_o  out    1   SPI clock, mode 0 (idle low)
//  external_qspi_cs_o  out    1   chip select, active low
// BEHAVIOUR
//  Reset: cs_o=1, ck_o=0, pins released (Z), rvalid_o=0, err_o=0, rdata_o=0, gnt_o=0.
//   State is IDLE; gnt_o=1 from the first cycle after rst deasserts.
//  States: IDLE -> CMD(2 ck) -> ADDR(6 ck) -> [DUMMY(DUMMY_CYC ck), read only] -> DATA -> CSHI -> IDLE.
//   Error path: IDLE -> RESP.
//  Acceptance (cycle T) latches addr/we/be/wdata. gnt_o=0 until back in IDLE; req_i is ignored meanwhile.
//  Reject at acceptance, with no SPI activity: addr_i[1:0]!=0, or a write with be_i==0,
//   or non-contiguous be_i (e.g. 0101). Response is rvalid_o=1, err_o=1 at T+1, then IDLE at T+2.
//  Write span: start byte = lowest set be bit b; nbytes = popcount(be_i).
//   SQI address = addr_i[23:0] + b. Only enabled bytes are sent.
//  Nibble order: opcode, then address MSB nibble first. Data is byte0 first (wdata[7:0]),
//   high nibble before low nibble within each byte.
//  N = ck_o periods: read = 8 + DUMMY_CYC + 8; write = 8 + 2*nbytes.
//  Timing: cs_o low from T+1 to T+2*N*CLK_DIV inclusive.
//   ck_o starts low, rises CLK_DIV clk after cs_o falls, and is low again at the end.
//  Output data changes on ck_o falling transitions; pins are sampled on ck_o rising.
//   The first nibble is driven when cs_o falls.
//  Pin drive: driven in CMD, ADDR and write DATA; released (Z) from the start of DUMMY
//   (or read DATA when DUMMY_CYC=0) to the end of the transaction.
//  Read DATA: 8 nibbles assembled into rdata_o in the order above.
//   rdata_o updates only on a successful read response and holds otherwise.
//  Response: at T+2*N*CLK_DIV+1, cs_o=1 and rvalid_o=1 for one cycle, err_o=0.
//   gnt_o reasserts at T+2*N*CLK_DIV+1+CS_HIGH_CYC.
//  rst mid-transaction: next cycle cs_o=1, ck_o=0, pins Z, no rvalid_o; request is dropped.
//  Back-to-back: a request held during busy is accepted on the first gnt_o cycle.
// TESTING
//  1 Reset: hold rst 3 cycles -> cs_o=1, ck_o=0, pins Z, rvalid_o=0; gnt_o=1 one cycle after release.
//  2 Write wdata=0x12345678 addr=0x100 be=1111, CLK_DIV=1
//    -> nibbles 0,2,0,0,0,1,0,0,7,8,5,6,3,4,1,2; rvalid_o at T+33, err_o=0.
//  3 Read addr=0x100, DUMMY_CYC=2; model drives 7,8,5,6,3,4,1,2
//    -> rdata_o=0x12345678, rvalid_o at T+37; pins Z from ck 9.
//  4 Write addr=0x40 be=0110 wdata=0xAABBCCDD -> address nibbles 000041, data C,C,B,B, N=12.
//  5 Write be=0101, then read addr=0x102 -> each gives rvalid_o=err_o=1 at T+1; cs_o never falls.
//  6 rst during read ADDR phase -> cs_o=1 next cycle, no rvalid_o; following read of 0x100 returns 0x12345678.

Source files
------------

// File: rtl/qspi_mem_ctrl.sv
// Quad-SPI (SQI) master for the external storage SRAM.
// Runs one single-word transaction per request: opcode, 24-bit address,
// optional dummy periods (reads only), then data.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | cs_o high, gnt_o high, waiting for a request
// CMD     | 2 ck periods, opcode nibbles driven
// ADDR    | 6 ck periods, address nibbles driven MSB first
// DUMMY   | DUMMY_CYC ck periods, pins released (reads only)
// DATA    | 8 nibbles read, or 2*nbytes nibbles written
// CSHI    | cs_o held high for CS_HIGH_CYC cycles after the response
// RESP    | one-cycle error response for a rejected request
module qspi_mem_ctrl #(
   parameter int         CLK_DIV     = 1,
   parameter int         DUMMY_CYC   = 2,
   parameter int         CS_HIGH_CYC = 2,
   parameter logic [7:0] READ_CMD    = 8'h03,
   parameter logic [7:0] WRITE_CMD   = 8'h02
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_i,
   output logic        gnt_o,
   input  logic [31:0] addr_i,
   input  logic        we_i,
   input  logic [3:0]  be_i,
   input  logic [31:0] wdata_i,
   output logic        rvalid_o,
   output logic        err_o,
   output logic [31:0] rdata_o,
   output logic        busy_o,
   inout  wire  [3:0]  external_qspi_pins,
   output logic        external_qspi_ck_o,
   output logic        external_qspi_cs_o
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CMD   = 3'd1;
   localparam logic [2:0] S_ADDR  = 3'd2;
   localparam logic [2:0] S_DUMMY = 3'd3;
   localparam logic [2:0] S_DATA  = 3'd4;
   localparam logic [2:0] S_CSHI  = 3'd5;
   localparam logic [2:0] S_RESP  = 3'd6;

   localparam logic [15:0] DIV_LOAD   = 16'(CLK_DIV - 1);
   localparam logic [15:0] CSH_LOAD   = 16'(CS_HIGH_CYC - 1);
   localparam logic [3:0]  DUMMY_LOAD = 4'(DUMMY_CYC - 1);

   logic [2:0]  state;
   logic [15:0] div_cnt;
   logic [15:0] csh_cnt;
   logic [3:0]  nib_cnt;
   logic [3:0]  data_last;
   logic        cs_q, ck_q, oe_q, we_q, gnt_q, rvalid_q, err_q;
   logic [63:0] tx_sr;
   logic [31:0] rx_sr;
   logic [31:0] rdata_q;

   logic        be_ok, req_bad;
   logic [1:0]  start_b;
   logic [2:0]  nbytes;
   logic [31:0] wsh, wseq;
   logic [23:0] sqi_addr;
   logic [3:0]  data_last_c;

   // Upper address bits are outside the 16 MB SRAM window.
   wire unused_addr = ^addr_i[31:24];

   // Decode byte enables into a contiguous span and build the outgoing stream.
   always_comb begin
      be_ok   = 1'b1;
      start_b = 2'd0;
      nbytes  = 3'd0;
      case (be_i)
         4'b0001: begin start_b = 2'd0; nbytes = 3'd1; end
         4'b0010: begin start_b = 2'd1; nbytes = 3'd1; end
         4'b0100: begin start_b = 2'd2; nbytes = 3'd1; end
         4'b1000: begin start_b = 2'd3; nbytes = 3'd1; end
         4'b0011: begin start_b = 2'd0; nbytes = 3'd2; end
         4'b0110: begin start_b = 2'd1; nbytes = 3'd2; end
         4'b1100: begin start_b = 2'd2; nbytes = 3'd2; end
         4'b0111: begin start_b = 2'd0; nbytes = 3'd3; end
         4'b1110: begin start_b = 2'd1; nbytes = 3'd3; end
         4'b1111: begin start_b = 2'd0; nbytes = 3'd4; end
         default: be_ok = 1'b0;
      endcase
      req_bad     = (addr_i[1:0] != 2'b00) || (we_i && !be_ok);
      wsh         = wdata_i >> {start_b, 3'b000};
      wseq        = {wsh[7:0], wsh[15:8], wsh[23:16], wsh[31:24]};
      sqi_addr    = addr_i[23:0] + {22'd0, (we_i ? start_b : 2'd0)};
      data_last_c = {nbytes, 1'b0} - 4'd1;
   end

   // Transaction sequencer: clock divider, shift registers and phase control.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         div_cnt   <= '0;
         csh_cnt   <= '0;
         nib_cnt   <= '0;
         data_last <= '0;
         cs_q      <= 1'b1;
         ck_q      <= 1'b0;
         oe_q      <= 1'b0;
         we_q      <= 1'b0;
         gnt_q     <= 1'b0;
         rvalid_q  <= 1'b0;
         err_q     <= 1'b0;
         tx_sr     <= '0;
         rx_sr     <= '0;
         rdata_q   <= '0;
      end else begin
         rvalid_q <= 1'b0;
         err_q    <= 1'b0;
         case (state)
            S_IDLE: begin
               if (req_i && gnt_q) begin
                  gnt_q <= 1'b0;
                  we_q  <= we_i;
                  if (req_bad) begin
                     state    <= S_RESP;
                     rvalid_q <= 1'b1;
                     err_q    <= 1'b1;
                  end else begin
                     state     <= S_CMD;
                     cs_q      <= 1'b0;
                     ck_q      <= 1'b0;
                     oe_q      <= 1'b1;
                     div_cnt   <= DIV_LOAD;
                     nib_cnt   <= 4'd1;
                     data_last <= data_last_c;
                     tx_sr     <= {(we_i ? WRITE_CMD : READ_CMD), sqi_addr,
                                   (we_i ? wseq : 32'h0)};
                  end
               end else begin
                  gnt_q <= 1'b1;
               end
            end
            S_RESP: begin
               state <= S_IDLE;
               gnt_q <= 1'b1;
            end
            S_CSHI: begin
               if (csh_cnt == 16'd0) begin
                  state <= S_IDLE;
                  gnt_q <= 1'b1;
               end else begin
                  csh_cnt <= csh_cnt - 16'd1;
               end
            end
            S_CMD, S_ADDR, S_DUMMY, S_DATA: begin
               if (div_cnt != 16'd0) begin
                  div_cnt <= div_cnt - 16'd1;
               end else begin
                  div_cnt <= DIV_LOAD;
                  if (!ck_q) begin
                     ck_q <= 1'b1;
                     if (state == S_DATA && !we_q)
                        rx_sr <= {rx_sr[27:0], external_qspi_pins};
                  end else begin
                     // Falling edge: next nibble goes out, phase may advance.
                     ck_q  <= 1'b0;
                     tx_sr <= {tx_sr[59:0], 4'h0};
                     if (nib_cnt != 4'd0) begin
                        nib_cnt <= nib_cnt - 4'd1;
                     end else begin
                        case (state)
                           S_CMD: begin
                              state   <= S_ADDR;
                              nib_cnt <= 4'd5;
                           end
                           S_ADDR: begin
                              if (we_q) begin
                                 state   <= S_DATA;
                                 nib_cnt <= data_last;
                              end else if (DUMMY_CYC > 0) begin
                                 state   <= S_DUMMY;
                                 nib_cnt <= DUMMY_LOAD;
                                 oe_q    <= 1'b0;
                              end else begin
                                 state   <= S_DATA;
                                 nib_cnt <= 4'd7;
                                 oe_q    <= 1'b0;
                              end
                           end
                           S_DUMMY: begin
                              state   <= S_DATA;
                              nib_cnt <= 4'd7;
                           end
                           default: begin
                              state    <= S_CSHI;
                              cs_q     <= 1'b1;
                              oe_q     <= 1'b0;
                              rvalid_q <= 1'b1;
                              csh_cnt  <= CSH_LOAD;
                              if (!we_q)
                                 rdata_q <= {rx_sr[7:0], rx_sr[15:8],
                                             rx_sr[23:16], rx_sr[31:24]};
                           end
                        endcase
                     end
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign external_qspi_pins = oe_q ? tx_sr[63:60] : 4'bzzzz;
   assign external_qspi_ck_o = ck_q;
   assign external_qspi_cs_o = cs_q;
   assign gnt_o              = gnt_q;
   assign busy_o             = ~gnt_q;
   assign rvalid_o           = rvalid_q;
   assign err_o              = err_q;
   assign rdata_o            = rdata_q;

endmodule
